// File: rtl/issue_scoreboard.sv
// Issue scoreboard: holds the decoded instruction until its sources, destination
// and the single long-latency unit are free, then marks the destination busy.
module issue_scoreboard #(
    parameter int          NREG      = 128,
    parameter logic [4:0]  LONG_CODE = 5'b11111,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [6:0]       dec_rs,
    input  logic             dec_rs_used,
    input  logic [6:0]       dec_rt,
    input  logic             dec_rt_used,
    input  logic [1:0]       dec_rw,
    input  logic [5:0]       dec_rd,
    input  logic [4:0]       dec_wait,
    input  logic             dec_stop,
    input  logic             flush,
    input  logic [1:0]       wb_rw,
    input  logic [5:0]       wb_rd,
    output logic             issue,
    output logic             stall,
    output logic             halted,
    output logic             done,
    output logic [CNT_W-1:0] stall_count
);

    logic [NREG-1:0]  w_busy;
    logic [NREG-1:0]  w_long;
    logic             r_long_busy;
    logic             r_halted;
    logic [CNT_W-1:0] r_stall_count;

    logic       w_d_valid;
    logic [6:0] w_d;
    logic       w_wb_valid;
    logic [6:0] w_wb;
    logic       w_src_haz;
    logic       w_waw_haz;
    logic       w_str_haz;
    logic       w_issue;
    logic       w_stall;
    logic       w_mark;
    logic       w_mark_long;
    logic       w_long_wb;

    always_comb begin
        w_d_valid   = (dec_rw == 2'b01) || (dec_rw == 2'b10);
        w_d         = {dec_rw == 2'b10, dec_rd};
        w_wb_valid  = (wb_rw == 2'b01) || (wb_rw == 2'b10);
        w_wb        = {wb_rw == 2'b10, wb_rd};
        w_long_wb   = w_wb_valid && w_long[w_wb];

        w_src_haz   = (dec_rs_used && w_busy[dec_rs]) || (dec_rt_used && w_busy[dec_rt]);
        w_waw_haz   = w_d_valid && w_busy[w_d];
        w_str_haz   = (dec_wait == LONG_CODE) && r_long_busy;

        // Outputs are forced low while reset is held, independent of the clock.
        w_issue     = !rst && dec_valid && !flush && !r_halted
                      && !w_src_haz && !w_waw_haz && !w_str_haz;
        w_stall     = !rst && dec_valid && !w_issue && !flush;

        // A stop marks nothing; a zero-latency result is forwarded.
        w_mark      = w_issue && !dec_stop && w_d_valid && (dec_wait != 5'd0);
        w_mark_long = (dec_wait == LONG_CODE);
    end

    assign issue       = w_issue;
    assign stall       = w_stall;
    assign halted      = r_halted;
    assign done        = !rst && r_halted && !(|w_busy);
    assign stall_count = r_stall_count;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            localparam logic [6:0] LP_IDX = 7'(gi);

            logic       r_busy;
            logic       r_long;
            logic [4:0] r_cnt;
            logic       w_hit;
            logic       w_wb_hit;

            assign w_hit    = w_mark && (w_d == LP_IDX);
            assign w_wb_hit = w_long_wb && (w_wb == LP_IDX);

            // New issue marking takes priority over expiry or writeback.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_busy <= 1'b0;
                    r_long <= 1'b0;
                    r_cnt  <= 5'd0;
                end else if (w_hit) begin
                    r_busy <= 1'b1;
                    r_long <= w_mark_long;
                    r_cnt  <= w_mark_long ? 5'd0 : dec_wait;
                end else if (r_long) begin
                    if (w_wb_hit) begin
                        r_busy <= 1'b0;
                        r_long <= 1'b0;
                    end
                end else if (r_busy) begin
                    if (r_cnt == 5'd1) begin
                        r_busy <= 1'b0;
                        r_cnt  <= 5'd0;
                    end else begin
                        r_cnt  <= r_cnt - 5'd1;
                    end
                end
            end

            assign w_busy[gi] = r_busy;
            assign w_long[gi] = r_long;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_long_busy <= 1'b0;
        end else if (w_mark && w_mark_long) begin
            r_long_busy <= 1'b1;
        end else if (w_long_wb) begin
            r_long_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_halted <= 1'b0;
        end else if (w_issue && dec_stop) begin
            r_halted <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_stall && !(&r_stall_count)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: directed scenarios plus random traffic, checked each
// cycle against a model that tracks per-register "free from cycle N" times.
module tb_issue_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_valid;
    logic [6:0]  dec_rs;
    logic        dec_rs_used;
    logic [6:0]  dec_rt;
    logic        dec_rt_used;
    logic [1:0]  dec_rw;
    logic [5:0]  dec_rd;
    logic [4:0]  dec_wait;
    logic        dec_stop;
    logic        flush;
    logic [1:0]  wb_rw;
    logic [5:0]  wb_rd;
    logic        issue;
    logic        stall;
    logic        halted;
    logic        done;
    logic [31:0] stall_count;

    issue_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .dec_valid   (dec_valid),
        .dec_rs      (dec_rs),
        .dec_rs_used (dec_rs_used),
        .dec_rt      (dec_rt),
        .dec_rt_used (dec_rt_used),
        .dec_rw      (dec_rw),
        .dec_rd      (dec_rd),
        .dec_wait    (dec_wait),
        .dec_stop    (dec_stop),
        .flush       (flush),
        .wb_rw       (wb_rw),
        .wb_rd       (wb_rd),
        .issue       (issue),
        .stall       (stall),
        .halted      (halted),
        .done        (done),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // Model: a non-long register is busy while cyc < m_ready; a long one until written back.
    bit          m_long  [128];
    int          m_ready [128];
    int          cyc = 0;
    bit          m_halted;
    logic [31:0] m_scnt;

    function automatic bit m_busy(input logic [6:0] r);
        return m_long[r] || (cyc < m_ready[r]);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 128; r++) begin
            m_long[r]  = 1'b0;
            m_ready[r] = 0;
        end
        m_halted = 1'b0;
        m_scnt   = '0;
    endtask

    // Called just after a falling edge with inputs applied; checks, then advances one clock.
    task automatic cycle();
        bit         e_iss, e_stall, any_long, any_busy, dv;
        logic [6:0] d, w;
        #1;
        dv = (dec_rw == 2'b01) || (dec_rw == 2'b10);
        d  = {dec_rw == 2'b10, dec_rd};
        any_long = 1'b0;
        any_busy = 1'b0;
        for (int r = 0; r < 128; r++) begin
            any_long |= m_long[r];
            any_busy |= m_busy(7'(r));
        end
        e_iss = dec_valid && !flush && !m_halted
                && !(dec_rs_used && m_busy(dec_rs))
                && !(dec_rt_used && m_busy(dec_rt))
                && !(dv && m_busy(d))
                && !(dec_wait == 5'd31 && any_long);
        e_stall = dec_valid && !e_iss && !flush;
        chk("issue",       {31'd0, issue},  {31'd0, e_iss});
        chk("stall",       {31'd0, stall},  {31'd0, e_stall});
        chk("halted",      {31'd0, halted}, {31'd0, m_halted});
        chk("done",        {31'd0, done},   {31'd0, m_halted && !any_busy});
        chk("stall_count", stall_count,     m_scnt);
        @(posedge clk);
        w = {wb_rw == 2'b10, wb_rd};
        if ((wb_rw == 2'b01 || wb_rw == 2'b10) && m_long[w]) m_long[w] = 1'b0;
        if (e_iss && dec_stop) begin
            m_halted = 1'b1;
        end else if (e_iss && dv && dec_wait != 5'd0) begin
            if (dec_wait == 5'd31) begin
                m_long[d]  = 1'b1;
                m_ready[d] = 0;
            end else begin
                m_long[d]  = 1'b0;
                m_ready[d] = cyc + 1 + int'(dec_wait);
            end
        end
        if (e_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic op(input bit v, input logic [6:0] rs, input bit rsu, input logic [6:0] rt,
                      input bit rtu, input logic [1:0] rw, input logic [5:0] rd,
                      input logic [4:0] w, input bit stop);
        dec_valid = v;   dec_rs = rs; dec_rs_used = rsu; dec_rt = rt; dec_rt_used = rtu;
        dec_rw = rw;     dec_rd = rd; dec_wait = w;      dec_stop = stop;
    endtask

    task automatic idle();
        op(1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 2'b00, 6'd0, 5'd0, 1'b0);
        flush = 1'b0;
        wb_rw = 2'b00;
        wb_rd = 6'd0;
    endtask

    // Raise reset between clock edges and confirm outputs clear without an edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_issue",  {31'd0, issue},  32'd0);
        chk("rst_stall",  {31'd0, stall},  32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_scnt",   stall_count,     32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] rv;
    int          k;

    initial begin
        rst = 1'b1;
        idle();
        dec_valid = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // FPR3 with wait 4, then a reader of FPR3: four stalls, issue on the fifth.
        op(1, 7'd0, 0, 7'd0, 0, 2'b10, 6'd3, 5'd4, 0);
        #1; chk("s1_first", {31'd0, issue}, 32'd1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            op(1, 7'd0, 0, 7'b1_000011, 1, 2'b00, 6'd0, 5'd0, 0);
            #1; chk("s1_reader", {31'd0, issue}, (i == 4) ? 32'd1 : 32'd0);
            cycle();
        end
        idle();
        #1; chk("s1_scnt", stall_count, 32'd4);
        cycle();

        // LW to GPR5 wait 3, then a writer of GPR5: three WAW stalls.
        op(1, 7'd0, 0, 7'd0, 0, 2'b01, 6'd5, 5'd3, 0);
        cycle();
        for (int i = 0; i < 4; i++) begin
            op(1, 7'd0, 0, 7'd0, 0, 2'b01, 6'd5, 5'd1, 0);
            #1; chk("s2_waw", {31'd0, issue}, (i == 3) ? 32'd1 : 32'd0);
            cycle();
        end
        idle();
        #1; chk("s2_scnt", stall_count, 32'd7);
        cycle();

        // DIV to GPR7, second DIV to GPR8 waits for GPR7 writeback.
        op(1, 7'd0, 0, 7'd0, 0, 2'b01, 6'd7, 5'd31, 0);
        cycle();
        op(1, 7'd0, 0, 7'd0, 0, 2'b01, 6'd8, 5'd31, 0);
        for (int i = 0; i < 3; i++) begin
            #1; chk("s3_hold", {31'd0, issue}, 32'd0);
            cycle();
        end
        wb_rw = 2'b01; wb_rd = 6'd7;
        #1; chk("s3_wbcyc", {31'd0, issue}, 32'd0);
        cycle();
        wb_rw = 2'b00;
        #1; chk("s3_after", {31'd0, issue}, 32'd1);
        cycle();
        idle();
        wb_rw = 2'b01; wb_rd = 6'd8;
        cycle();
        idle();

        // Zero-latency result to GPR2 is forwarded.
        op(1, 7'd0, 0, 7'd0, 0, 2'b01, 6'd2, 5'd0, 0);
        cycle();
        op(1, 7'd2, 1, 7'd0, 0, 2'b00, 6'd0, 5'd0, 0);
        #1; chk("s4_fwd", {31'd0, issue}, 32'd1);
        cycle();

        // Flush with a clean offer: no issue, no stall counted.
        rv = stall_count;
        op(1, 7'd1, 1, 7'd0, 0, 2'b01, 6'd10, 5'd2, 0);
        flush = 1'b1;
        #1; chk("s5_fl_issue", {31'd0, issue}, 32'd0);
        chk("s5_fl_stall", {31'd0, stall}, 32'd0);
        cycle();
        flush = 1'b0;
        #1; chk("s5_fl_scnt", stall_count, rv);
        chk("s5_next", {31'd0, issue}, 32'd1);
        cycle();
        idle();
        cycle(); cycle();

        // Long op then stop: halted, draining, done after writeback.
        op(1, 7'd0, 0, 7'd0, 0, 2'b10, 6'd9, 5'd31, 0);
        cycle();
        op(1, 7'd0, 0, 7'd0, 0, 2'b00, 6'd0, 5'd0, 1);
        cycle();
        op(1, 7'd0, 0, 7'd0, 0, 2'b01, 6'd20, 5'd1, 0);
        #1; chk("s6_halted", {31'd0, halted}, 32'd1);
        chk("s6_nodone", {31'd0, done}, 32'd0);
        chk("s6_noiss", {31'd0, issue}, 32'd0);
        cycle(); cycle();
        wb_rw = 2'b10; wb_rd = 6'd9;
        cycle();
        wb_rw = 2'b00;
        #1; chk("s6_done", {31'd0, done}, 32'd1);
        cycle();
        do_reset();

        // Reset in the middle of a drain.
        op(1, 7'd0, 0, 7'd0, 0, 2'b01, 6'd0, 5'd31, 0);
        cycle();
        op(1, 7'd0, 0, 7'd0, 0, 2'b00, 6'd0, 5'd0, 1);
        cycle();
        op(1, 7'd0, 0, 7'd0, 0, 2'b00, 6'd0, 5'd0, 0);
        #1; chk("s7_halted", {31'd0, halted}, 32'd1);
        cycle();
        do_reset();
        idle();
        #1; chk("s7_clear", {31'd0, halted}, 32'd0);
        cycle();

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            rv = $urandom;
            dec_valid   = ($urandom_range(0, 9) != 0);
            dec_rs      = {rv[0], 3'b000, rv[3:1]};
            dec_rs_used = rv[4];
            dec_rt      = {rv[5], 3'b000, rv[8:6]};
            dec_rt_used = rv[9];
            dec_rw      = rv[11:10];
            dec_rd      = {3'b000, rv[14:12]};
            k = $urandom_range(0, 9);
            dec_wait    = (k <= 6) ? 5'(k) : ((k == 7) ? 5'd30 : 5'd31);
            dec_stop    = ($urandom_range(0, 149) == 0);
            flush       = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                wb_rw = rv[16:15];
                wb_rd = {3'b000, rv[19:17]};
            end else begin
                wb_rw = 2'b00;
                wb_rd = 6'd0;
            end
            if ((m_halted && $urandom_range(0, 19) == 0) || $urandom_range(0, 399) == 0)
                do_reset();
            else
                cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
